pipeline_hazard_ctrl: RTL

Central stall/flush controller for the five-stage RISC-V pipeline. Each cycle it decides whether the PC advances and whether the IF/ID and ID/EX pipeline registers hold, load normally or load a bubble. Causes handled: data-memory wait, taken branch/jump redirect, load-use hazard, instruction-memory wait. A small FSM discards a stale in-flight fetch after a redirect, and two saturating counters expose stall and flush statistics.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 35 +++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: FSM state, register-index width, the
// per-register stall/flush bundle and the load-use hazard test.
package pipeline_hazard_ctrl_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = '0;

   // Fetch-side FSM: RUN is normal flow, DISCARD throws away a stale fetch
   // that was already in flight when a redirect was accepted.
   typedef enum logic {
      RUN     = 1'b0,
      DISCARD = 1'b1
   } state_e;

   // Control bundle used by every pipeline register.
   typedef struct packed {
      logic stall;
      logic flush;
   } stage_ctrl_t;

   // A load in EX whose destination is read by the instruction in ID.
   // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
   function automatic logic load_use_hazard(
      input logic             mem_read,
      input logic [REG_W-1:0] rd,
      input logic [REG_W-1:0] rs1,
      input logic             uses_rs1,
      input logic [REG_W-1:0] rs2,
      input logic             uses_rs2
   );
      return mem_read && (rd != ZERO_REG) &&
             ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts enabled cycles, sticks at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc_en,
   output logic [W-1:0] count
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: increment when enabled unless already saturated.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      cnt_d = cnt_q;
      if (inc_en && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register, cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline. Decides every
// cycle whether the PC advances and whether IF/ID, ID/EX and EX/MEM hold,
// load, or load a bubble. Decisions are combinational; only the discard FSM
// and the statistics counters are registered.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_redirect,
   input  logic             imem_busy,
   input  logic             dmem_busy,
   output logic             pc_write_en,
   output logic             pc_sel_redirect,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   state_e      state_q;
   state_e      state_d;
   stage_ctrl_t if_id_c;
   stage_ctrl_t id_ex_c;
   stage_ctrl_t ex_mem_c;
   logic        redirect_accept;
   logic        load_use;

   assign load_use = load_use_hazard(ex_mem_read, ex_rd, id_rs1, id_uses_rs1,
                                     id_rs2, id_uses_rs2);

   // State register; reset returns to RUN immediately, even mid-discard.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: enter DISCARD when a redirect is taken while a fetch is
   // still outstanding; leave on the cycle that stale fetch completes.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (!dmem_busy && ex_redirect && imem_busy) begin
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (!imem_busy) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Control outputs from state and inputs, highest-priority cause first.
   always_comb begin
      pc_write_en     = 1'b1;
      pc_sel_redirect = 1'b0;
      redirect_accept = 1'b0;
      if_id_c         = '0;
      id_ex_c         = '0;
      ex_mem_c        = '0;

      if (reset) begin
         // Keep the pipeline empty and the PC still while held in reset.
         pc_write_en   = 1'b0;
         if_id_c.flush = 1'b1;
         id_ex_c.flush = 1'b1;
      end else if (state_q == DISCARD) begin
         // The fetch in flight belongs to the old path: never let it into ID.
         pc_write_en   = 1'b0;
         if_id_c.flush = 1'b1;
         if (dmem_busy) begin
            // Freeze the back end; IF/ID keeps flushing rather than holding.
            id_ex_c.stall  = 1'b1;
            ex_mem_c.stall = 1'b1;
         end
      end else if (dmem_busy) begin
         // Whole pipe freezes; a pending redirect waits in EX.
         pc_write_en    = 1'b0;
         if_id_c.stall  = 1'b1;
         id_ex_c.stall  = 1'b1;
         ex_mem_c.stall = 1'b1;
      end else if (ex_redirect) begin
         pc_sel_redirect = 1'b1;
         redirect_accept = 1'b1;
         if_id_c.flush   = 1'b1;
         id_ex_c.flush   = 1'b1;
      end else if (load_use) begin
         // Hold the consumer in ID and insert one bubble into EX.
         pc_write_en   = 1'b0;
         if_id_c.stall = 1'b1;
         id_ex_c.flush = 1'b1;
      end else if (imem_busy) begin
         // No instruction yet: feed a bubble into ID, later stages flow.
         pc_write_en   = 1'b0;
         if_id_c.flush = 1'b1;
      end
   end

   assign if_id_stall  = if_id_c.stall;
   assign if_id_flush  = if_id_c.flush;
   assign id_ex_stall  = id_ex_c.stall;
   assign id_ex_flush  = id_ex_c.flush;
   assign ex_mem_stall = ex_mem_c.stall;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc_en (~pc_write_en & ~reset),
      .count  (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc_en (redirect_accept),
      .count  (flush_events)
   );

endmodule
